// File: rtl/csr_timer_bank.sv
// csr_timer_bank: NUM_TIMERS independent down-counting CSR timers (TCFG/TVAL/TICLR per
// channel, masked writes, sticky pending flags) plus a free-running stable counter.
// Optional feature macro: TIMER_PRESCALE_EN adds a per-channel prescaler register at
// csr_addr 3 and narrows the stored TCFG to TIMESIZE-PRESCALE_W bits. The prescaled
// build needs TIMESIZE >= PRESCALE_W + 3.

module csr_timer_bank #(
  parameter int NUM_TIMERS = 2,
  parameter int TIMESIZE   = 32,
  parameter int CNT_WIDTH  = 64,
  parameter int SEL_W      = 3
`ifdef TIMER_PRESCALE_EN
  ,
  parameter int PRESCALE_W = 8
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  csr_we,
  input  logic [SEL_W-1:0]      csr_sel,
  input  logic [1:0]            csr_addr,
  input  logic [31:0]           csr_wdata,
  input  logic [31:0]           csr_wmask,
  output logic [31:0]           csr_rdata,
  output logic [NUM_TIMERS-1:0] timer_irq,
  output logic                  irq_any,
  output logic [31:0]           counter_hi,
  output logic [31:0]           counter_lo
);

`ifdef TIMER_PRESCALE_EN
  localparam int CFG_W = TIMESIZE - PRESCALE_W;
`else
  localparam int CFG_W = TIMESIZE;
`endif

  localparam logic [1:0] ADDR_TCFG  = 2'd0;
  localparam logic [1:0] ADDR_TVAL  = 2'd1;
  localparam logic [1:0] ADDR_TICLR = 2'd2;
  localparam logic [1:0] ADDR_PSC   = 2'd3;

  logic [CFG_W-1:0]     tcfg_arr [NUM_TIMERS];
  logic [TIMESIZE-1:0]  tval_arr [NUM_TIMERS];
`ifdef TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] psc_arr [NUM_TIMERS];
`endif
  logic [CNT_WIDTH-1:0] stable_cnt;
  logic [31:0]          merged;
  logic                 unused_merged_bits;

  // The current read value doubles as the "old" word of a masked write, so TICLR
  // (which reads 0) only ever sees the bits actually written.
  assign merged             = (csr_wdata & csr_wmask) | (csr_rdata & ~csr_wmask);
  assign unused_merged_bits = ^merged;

  // Read mux: out-of-range channels never match, so they read 0.
  always_comb begin
    csr_rdata = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (csr_sel == SEL_W'(i)) begin
        case (csr_addr)
          ADDR_TCFG: csr_rdata = 32'(tcfg_arr[i]);
          ADDR_TVAL: csr_rdata = 32'(tval_arr[i]);
`ifdef TIMER_PRESCALE_EN
          ADDR_PSC:  csr_rdata = 32'(psc_arr[i]);
`endif
          default:   csr_rdata = '0;
        endcase
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_TIMERS; g++) begin : gen_ch
      logic                sel_hit;
      logic                cfg_wr;
      logic                clr_wr;
      logic                tick;
      logic                active;
      logic                expire;
      logic                pend_q;
      logic [CFG_W-1:0]    tcfg_q;
      logic [CFG_W-1:0]    new_cfg;
      logic [TIMESIZE-1:0] tval_q;
      logic [TIMESIZE-1:0] reload_cur;
      logic [TIMESIZE-1:0] reload_new;

      assign sel_hit    = csr_we && (csr_sel == SEL_W'(g));
      assign cfg_wr     = sel_hit && (csr_addr == ADDR_TCFG);
      assign clr_wr     = sel_hit && (csr_addr == ADDR_TICLR) && merged[0];
      assign new_cfg    = merged[CFG_W-1:0];
      assign reload_cur = TIMESIZE'({tcfg_q[CFG_W-1:2], 2'b00});
      assign reload_new = TIMESIZE'({new_cfg[CFG_W-1:2], 2'b00});
      assign active     = tcfg_q[0] && (tval_q != '0) && tick;
      assign expire     = active && (tval_q == TIMESIZE'(1));

`ifdef TIMER_PRESCALE_EN
      logic                  psc_wr;
      logic [PRESCALE_W-1:0] psc_q;
      logic [PRESCALE_W-1:0] pcnt_q;

      assign psc_wr = sel_hit && (csr_addr == ADDR_PSC);
      assign tick   = (pcnt_q == psc_q);

      // Prescale register and private divider; the divider restarts on every TCFG write.
      always_ff @(posedge clk) begin
        if (reset) begin
          psc_q  <= '0;
          pcnt_q <= '0;
        end else begin
          if (psc_wr) psc_q <= merged[PRESCALE_W-1:0];
          if (cfg_wr) begin
            pcnt_q <= '0;
          end else if (tcfg_q[0] && (tval_q != '0)) begin
            pcnt_q <= tick ? '0 : pcnt_q + PRESCALE_W'(1);
          end
        end
      end

      assign psc_arr[g] = psc_q;
`else
      assign tick = 1'b1;
`endif

      // Channel state: TCFG write reloads TVAL and beats the expiry reload; a set of
      // pending on expiry beats a same-cycle TICLR so no event is lost.
      always_ff @(posedge clk) begin
        if (reset) begin
          tcfg_q <= '0;
          tval_q <= '0;
          pend_q <= 1'b0;
        end else begin
          if (cfg_wr) begin
            tcfg_q <= new_cfg;
            tval_q <= reload_new;
          end else if (expire) begin
            tval_q <= tcfg_q[1] ? reload_cur : '0;
          end else if (active) begin
            tval_q <= tval_q - TIMESIZE'(1);
          end
          if (expire) begin
            pend_q <= 1'b1;
          end else if (clr_wr) begin
            pend_q <= 1'b0;
          end
        end
      end

      assign tcfg_arr[g]  = tcfg_q;
      assign tval_arr[g]  = tval_q;
      assign timer_irq[g] = pend_q;
    end
  endgenerate

  // Stable counter: free-running, wraps naturally, never stalls.
  always_ff @(posedge clk) begin
    if (reset) stable_cnt <= '0;
    else       stable_cnt <= stable_cnt + CNT_WIDTH'(1);
  end

  assign counter_lo = stable_cnt[31:0];
  assign counter_hi = 32'(stable_cnt[CNT_WIDTH-1:32]);
  assign irq_any    = |timer_irq;

endmodule

// File: tb/tb_csr_timer_bank.sv
// tb_csr_timer_bank: directed table of register vectors plus hand-written timing
// sequences for expiry latency, periodic reload, TICLR races, reset and counter carry.

module tb_csr_timer_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        csr_we;
  logic [2:0]  csr_sel;
  logic [1:0]  csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_wmask;
  logic [31:0] csr_rdata;
  logic [1:0]  timer_irq;
  logic        irq_any;
  logic [31:0] counter_hi;
  logic [31:0] counter_lo;

  logic [31:0] d33_rdata;
  logic [1:0]  d33_irq;
  logic        d33_any;
  logic [31:0] d33_hi;
  logic [31:0] d33_lo;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  csr_timer_bank dut (
    .clk(clk), .reset(reset), .csr_we(csr_we), .csr_sel(csr_sel), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_wmask(csr_wmask), .csr_rdata(csr_rdata),
    .timer_irq(timer_irq), .irq_any(irq_any), .counter_hi(counter_hi), .counter_lo(counter_lo)
  );

  csr_timer_bank #(.CNT_WIDTH(33)) dut33 (
    .clk(clk), .reset(reset), .csr_we(1'b0), .csr_sel(3'd0), .csr_addr(2'd0),
    .csr_wdata(32'd0), .csr_wmask(32'd0), .csr_rdata(d33_rdata),
    .timer_irq(d33_irq), .irq_any(d33_any), .counter_hi(d33_hi), .counter_lo(d33_lo)
  );

  typedef struct {
    logic        we;
    logic [2:0]  sel;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] wmask;
    logic [2:0]  rsel;
    logic [1:0]  raddr;
    logic [31:0] exp_rdata;
  } vec_t;

`ifdef TIMER_PRESCALE_EN
  localparam logic [31:0] PSC_EXP = 32'h55;
`else
  localparam logic [31:0] PSC_EXP = 32'h0;
`endif

  vec_t vecs [15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [2:0] sel, input logic [1:0] addr,
                               input logic [31:0] wdata, input logic [31:0] wmask);
    @(negedge clk);
    csr_we    = we;
    csr_sel   = sel;
    csr_addr  = addr;
    csr_wdata = wdata;
    csr_wmask = wmask;
    @(posedge clk);
    #1;
    csr_we = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic readReg(input logic [2:0] sel, input logic [1:0] addr);
    csr_sel  = sel;
    csr_addr = addr;
    #1;
  endtask

  task automatic waitIrq(input int ch, input int limit, inout int k);
    while (timer_irq[ch] == 1'b0 && k < limit) begin
      step();
      k++;
    end
  endtask

  initial begin
    int k;

    vecs[0]  = '{1'b1, 3'd0, 2'd0, 32'h0000_0010, 32'hFFFF_FFFF, 3'd0, 2'd0, 32'h0000_0010};
    vecs[1]  = '{1'b0, 3'd0, 2'd0, 32'h0,         32'h0,         3'd0, 2'd1, 32'h0000_0010};
    vecs[2]  = '{1'b1, 3'd1, 2'd0, 32'h0000_0026, 32'hFFFF_FFFF, 3'd1, 2'd0, 32'h0000_0026};
    vecs[3]  = '{1'b0, 3'd0, 2'd0, 32'h0,         32'h0,         3'd1, 2'd1, 32'h0000_0024};
    vecs[4]  = '{1'b1, 3'd1, 2'd0, 32'hFFFF_FFF0, 32'h0000_00F0, 3'd1, 2'd0, 32'h0000_00F6};
    vecs[5]  = '{1'b0, 3'd0, 2'd0, 32'h0,         32'h0,         3'd1, 2'd1, 32'h0000_00F4};
    vecs[6]  = '{1'b0, 3'd0, 2'd0, 32'h0,         32'h0,         3'd0, 2'd0, 32'h0000_0010};
    vecs[7]  = '{1'b1, 3'd5, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd5, 2'd0, 32'h0};
    vecs[8]  = '{1'b0, 3'd0, 2'd0, 32'h0,         32'h0,         3'd0, 2'd0, 32'h0000_0010};
    vecs[9]  = '{1'b0, 3'd0, 2'd0, 32'h0,         32'h0,         3'd1, 2'd0, 32'h0000_00F6};
    vecs[10] = '{1'b1, 3'd0, 2'd1, 32'h0000_1234, 32'hFFFF_FFFF, 3'd0, 2'd1, 32'h0000_0010};
    vecs[11] = '{1'b1, 3'd0, 2'd2, 32'h0000_0001, 32'hFFFF_FFFF, 3'd0, 2'd2, 32'h0};
    vecs[12] = '{1'b1, 3'd0, 2'd3, 32'h0000_0055, 32'hFFFF_FFFF, 3'd0, 2'd3, PSC_EXP};
    vecs[13] = '{1'b1, 3'd0, 2'd3, 32'h0,         32'hFFFF_FFFF, 3'd0, 2'd3, 32'h0};
    vecs[14] = '{1'b0, 3'd0, 2'd0, 32'h0,         32'h0,         3'd7, 2'd1, 32'h0};

    reset = 1'b1; csr_we = 1'b0; csr_sel = '0; csr_addr = '0; csr_wdata = '0; csr_wmask = '0;
    repeat (3) step();
    readReg(3'd0, 2'd0); checkOutput("reset_tcfg", csr_rdata, 32'h0);
    readReg(3'd1, 2'd1); checkOutput("reset_tval", csr_rdata, 32'h0);
    checkOutput("reset_irq", 32'(timer_irq), 32'h0);
    checkOutput("reset_irq_any", 32'(irq_any), 32'h0);
    checkOutput("reset_cnt_lo", counter_lo, 32'h0);
    checkOutput("reset_cnt_hi", counter_hi, 32'h0);
    @(negedge clk); reset = 1'b0;
    repeat (5) step();
    checkOutput("cnt_runs", counter_lo, 32'd5);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].we, vecs[i].sel, vecs[i].addr, vecs[i].wdata, vecs[i].wmask);
      readReg(vecs[i].rsel, vecs[i].raddr);
      checkOutput($sformatf("vec%0d_rdata", i), csr_rdata, vecs[i].exp_rdata);
      checkOutput($sformatf("vec%0d_irq", i), 32'(timer_irq), 32'h0);
    end

    // One-shot channel 0, InitVal 4 -> TVAL 16, interrupt 17 cycles after the write.
    applyStimulus(1'b1, 3'd0, 2'd0, 32'h11, 32'hFFFF_FFFF);
    k = 1;
    readReg(3'd0, 2'd1); checkOutput("oneshot_load", csr_rdata, 32'h10);
    while (timer_irq[0] == 1'b0 && k < 40) begin
      step();
      k++;
      if (k == 16) checkOutput("oneshot_tval1", csr_rdata, 32'h1);
    end
    checkOutput("oneshot_latency", 32'(k), 32'd17);
    checkOutput("oneshot_tval0", csr_rdata, 32'h0);
    applyStimulus(1'b1, 3'd0, 2'd2, 32'h1, 32'hFFFF_FFFF);
    checkOutput("oneshot_clr", 32'(timer_irq[0]), 32'h0);
    repeat (20) step();
    checkOutput("oneshot_no_refire", 32'(timer_irq[0]), 32'h0);
    readReg(3'd0, 2'd1); checkOutput("oneshot_hold", csr_rdata, 32'h0);

    // Periodic channel 1, InitVal 2 -> reload 8.
    applyStimulus(1'b1, 3'd1, 2'd0, 32'h0B, 32'hFFFF_FFFF);
    k = 1;
    readReg(3'd1, 2'd1);
    waitIrq(1, 40, k);
    checkOutput("periodic_first", 32'(k), 32'd9);
    checkOutput("periodic_any_hi", 32'(irq_any), 32'h1);
    applyStimulus(1'b1, 3'd1, 2'd2, 32'h1, 32'hFFFF_FFFF);
    k++;
    checkOutput("periodic_clr", 32'(timer_irq[1]), 32'h0);
    checkOutput("periodic_any_lo", 32'(irq_any), 32'h0);
    readReg(3'd1, 2'd1);
    waitIrq(1, 40, k);
    checkOutput("periodic_second", 32'(k), 32'd17);
    checkOutput("periodic_any_again", 32'(irq_any), 32'h1);

    // TICLR issued on the exact expiry cycle: the set must win.
    applyStimulus(1'b1, 3'd1, 2'd2, 32'h1, 32'hFFFF_FFFF);
    k++;
    readReg(3'd1, 2'd1);
    while (k < 24) begin
      step();
      k++;
    end
    checkOutput("race_pre_irq", 32'(timer_irq[1]), 32'h0);
    checkOutput("race_pre_tval", csr_rdata, 32'h1);
    applyStimulus(1'b1, 3'd1, 2'd2, 32'h1, 32'hFFFF_FFFF);
    k++;
    checkOutput("race_set_wins", 32'(timer_irq[1]), 32'h1);

    // TCFG rewrite on the expiry cycle: pending set, TVAL takes the new reload.
    applyStimulus(1'b1, 3'd1, 2'd2, 32'h1, 32'hFFFF_FFFF);
    k++;
    checkOutput("cfgrace_clr", 32'(timer_irq[1]), 32'h0);
    readReg(3'd1, 2'd1);
    while (k < 32) begin
      step();
      k++;
    end
    checkOutput("cfgrace_pre_tval", csr_rdata, 32'h1);
    applyStimulus(1'b1, 3'd1, 2'd0, 32'h0F, 32'hFFFF_FFFF);
    checkOutput("cfgrace_irq", 32'(timer_irq[1]), 32'h1);
    readReg(3'd1, 2'd1); checkOutput("cfgrace_tval", csr_rdata, 32'h0C);

    // Masked write clearing only En on channel 0.
    applyStimulus(1'b1, 3'd0, 2'd0, 32'h0, 32'h1);
    readReg(3'd0, 2'd0); checkOutput("mask_tcfg", csr_rdata, 32'h10);
    repeat (5) step();
    readReg(3'd0, 2'd1); checkOutput("mask_tval_frozen", csr_rdata, 32'h10);

    // Reset in the middle of channel 1 counting.
    @(negedge clk); reset = 1'b1;
    step();
    checkOutput("midreset_irq", 32'(timer_irq), 32'h0);
    readReg(3'd1, 2'd0); checkOutput("midreset_tcfg", csr_rdata, 32'h0);
    readReg(3'd1, 2'd1); checkOutput("midreset_tval", csr_rdata, 32'h0);
    @(negedge clk); reset = 1'b0;
    repeat (20) step();
    checkOutput("midreset_quiet", 32'(timer_irq), 32'h0);
    checkOutput("midreset_cnt", counter_lo, 32'd20);

    // Stable counter carry into the high word, and a full 33-bit wrap.
    @(negedge clk);
    force dut.stable_cnt = 64'h0000_0000_FFFF_FFFE;
    force dut33.stable_cnt = 33'h1_FFFF_FFFE;
    #1;
    release dut.stable_cnt;
    release dut33.stable_cnt;
    step();
    checkOutput("carry_lo_pre", counter_lo, 32'hFFFF_FFFF);
    checkOutput("carry_hi_pre", counter_hi, 32'h0);
    checkOutput("w33_hi_pre", d33_hi, 32'h1);
    step();
    checkOutput("carry_lo", counter_lo, 32'h0);
    checkOutput("carry_hi", counter_hi, 32'h1);
    checkOutput("w33_hi", d33_hi, 32'h0);
    checkOutput("w33_lo", d33_lo, 32'h0);

`ifdef TIMER_PRESCALE_EN
    // Prescale 3 stretches a TVAL of 4 to an expiry in cycle 16.
    applyStimulus(1'b1, 3'd0, 2'd3, 32'h3, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 3'd0, 2'd0, 32'h05, 32'hFFFF_FFFF);
    k = 1;
    waitIrq(0, 60, k);
    checkOutput("psc3_latency", 32'(k), 32'd17);
    applyStimulus(1'b1, 3'd0, 2'd2, 32'h1, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 3'd0, 2'd3, 32'h0, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 3'd0, 2'd0, 32'h05, 32'hFFFF_FFFF);
    k = 1;
    waitIrq(0, 60, k);
    checkOutput("psc0_latency", 32'(k), 32'd5);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
